// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI receiver and voice parser.
package midi_pkg;

   localparam logic [3:0] NOTE_ON      = 4'h9;
   localparam logic [3:0] NOTE_OFF     = 4'h8;
   localparam logic [7:0] REALTIME_MIN = 8'hF8;
   localparam int         OMNI         = 16;

   typedef enum logic [1:0] {
      NONE,
      ON,
      OFF
   } run_status_t;

   typedef enum logic [2:0] {
      ARM,
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   // Gain word: velocity in the top bits, its top three bits replicated below
   // so that full velocity reaches full scale.
   function automatic logic [9:0] amp_of(input logic [6:0] vel);
      return {vel, vel[6:4]};
   endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM, byte and
// framing-error strobes.
module midi_uart_rx #(
   parameter int CLKSPEED = 48_000_000,
   parameter int BAUD     = 31250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);
   import midi_pkg::*;

   localparam int DIV = CLKSPEED / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

   logic              rx_meta;
   logic              rxs;
   uart_state_t       state;
   uart_state_t       state_next;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_next;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_idx_next;
   logic [7:0]        shift;
   logic [7:0]        shift_next;
   logic              valid_next;
   logic              ferr_next;

   // Synchroniser resets low so ARM only releases once the real line is seen high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b0;
         rxs     <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // State, bit timer, bit index, shift register and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARM;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         bit_idx    <= bit_idx_next;
         shift      <= shift_next;
         byte_valid <= valid_next;
         frame_err  <= ferr_next;
      end
   end

   // Next-state logic; every sample happens when the down-counter reaches zero.
   always_comb begin
      state_next   = state;
      cnt_next     = (cnt == '0) ? cnt : cnt - 1'b1;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      valid_next   = 1'b0;
      ferr_next    = 1'b0;
      case (state)
         ARM: begin
            if (rxs) state_next = IDLE;
         end
         IDLE: begin
            if (!rxs) begin
               state_next = START;
               cnt_next   = HALF_LOAD;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (!rxs) begin
                  state_next   = DATA;
                  cnt_next     = FULL_LOAD;
                  bit_idx_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shift_next   = {rxs, shift[7:1]};
               cnt_next     = FULL_LOAD;
               bit_idx_next = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               if (rxs) begin
                  valid_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = ARM;
               end
            end
         end
         default: state_next = ARM;
      endcase
   end

   assign rx_byte = shift;

endmodule

// File: rtl/midi_voice_rx.sv
// MIDI receiver plus monophonic Note On/Off parser driving note, gate,
// frequency-modulation and amplitude words. The event strobe is called
// note_event because "event" is a reserved word in SystemVerilog.
module midi_voice_rx #(
   parameter int CLKSPEED = 48_000_000,
   parameter int BAUD     = 31250,
   parameter int CHANNEL  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic       gate,
   output logic [9:0] freq_mod,
   output logic [9:0] amp,
   output logic       note_event,
   output logic       frame_err
);
   import midi_pkg::*;

   logic [7:0]  rx_byte;
   logic        byte_valid;
   run_status_t rs;
   logic        di_second;
   logic [6:0]  pend_note;
   logic        ch_ok;

   midi_uart_rx #(
      .CLKSPEED (CLKSPEED),
      .BAUD     (BAUD)
   ) u_uart (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // Channel nibble of the current byte matches, or omni accepts everything.
   always_comb begin
      ch_ok = (CHANNEL == OMNI) || (rx_byte[3:0] == 4'(CHANNEL));
   end

   // Running-status parser and registered voice outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs         <= NONE;
         di_second  <= 1'b0;
         pend_note  <= '0;
         note       <= '0;
         velocity   <= '0;
         gate       <= 1'b0;
         freq_mod   <= '0;
         amp        <= '0;
         note_event <= 1'b0;
      end else begin
         note_event <= 1'b0;
         if (byte_valid) begin
            if (rx_byte[7]) begin
               if (rx_byte < REALTIME_MIN) begin
                  if (rx_byte[7:4] == NOTE_ON && ch_ok) begin
                     rs        <= ON;
                     di_second <= 1'b0;
                  end else if (rx_byte[7:4] == NOTE_OFF && ch_ok) begin
                     rs        <= OFF;
                     di_second <= 1'b0;
                  end else begin
                     rs <= NONE;
                  end
               end
            end else if (rs != NONE) begin
               if (!di_second) begin
                  pend_note <= rx_byte[6:0];
                  di_second <= 1'b1;
               end else begin
                  di_second  <= 1'b0;
                  note_event <= 1'b1;
                  if (rs == ON && rx_byte[6:0] != 7'd0) begin
                     note     <= pend_note;
                     velocity <= rx_byte[6:0];
                     gate     <= 1'b1;
                     freq_mod <= {pend_note, 3'b000};
                     amp      <= amp_of(rx_byte[6:0]);
                  end else if (pend_note == note) begin
                     gate <= 1'b0;
                     amp  <= '0;
                  end
               end
            end
         end
      end
   end

endmodule
